// File: rtl/alarm_mode_controller.sv
// Alarm clock mode sequencer: edits time/alarm fields, detects alarm/snooze matches, drives ring.
// All outputs registered, one cycle after the causing input; pulse inputs, no backpressure.
module alarm_mode_controller #(
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_SECONDS = 60,
  parameter int ALARM_H_INIT = 6,
  parameter int ALARM_M_INIT = 0
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_alarm,
  input  logic       btn_snooze,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  output logic [2:0] state,
  output logic [5:0] inseconds,
  output logic [5:0] inminutes,
  output logic [4:0] inhours,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       alarm_en,
  output logic       ringing,
  output logic       snooze_active
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4,
    RING   = 3'd5
  } mode_t;

  localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

  mode_t      st;
  logic [4:0] snz_h;
  logic [5:0] snz_m;
  logic [7:0] ring_cnt;
  logic [5:0] prev_seconds;
  logic       match_prev;

  function automatic logic [4:0] step_hr(input logic [4:0] h, input logic up);
    logic [4:0] r;
    if (up) r = (h >= 5'd23) ? 5'd0 : h + 5'd1;
    else    r = (h == 5'd0) ? 5'd23 : h - 5'd1;
    return r;
  endfunction

  function automatic logic [5:0] step_min(input logic [5:0] m, input logic up);
    logic [5:0] r;
    if (up) r = (m >= 6'd59) ? 6'd0 : m + 6'd1;
    else    r = (m == 6'd0) ? 6'd59 : m - 6'd1;
    return r;
  endfunction

  logic       edit_up, edit, alarm_hit, snooze_hit, raw_match, match_rise, sec_changed;
  logic [6:0] snz_sum;
  logic [5:0] snz_m_next;
  logic [4:0] snz_h_next;

  assign edit_up     = btn_up & ~btn_down;
  assign edit        = btn_up ^ btn_down;
  assign alarm_hit   = alarm_en && hours == alarm_hours && minutes == alarm_minutes && seconds == 6'd0;
  assign snooze_hit  = snooze_active && hours == snz_h && minutes == snz_m && seconds == 6'd0;
  assign raw_match   = alarm_hit | snooze_hit;
  // History tracks the raw match in every mode, so a match that starts during
  // SET or RING never produces a late rising edge once back in RUN.
  assign match_rise  = raw_match & ~match_prev;
  assign sec_changed = seconds != prev_seconds;

  assign snz_sum    = {1'b0, minutes} + 7'(SNOOZE_MIN);
  assign snz_m_next = (snz_sum >= 7'd60) ? 6'(snz_sum - 7'd60) : snz_sum[5:0];
  assign snz_h_next = (snz_sum >= 7'd60) ? step_hr(hours, 1'b1) : hours;

  assign state = st;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      st            <= RUN;
      inseconds     <= 6'd0;
      inminutes     <= 6'd0;
      inhours       <= 5'd0;
      alarm_hours   <= 5'(ALARM_H_INIT);
      alarm_minutes <= 6'(ALARM_M_INIT);
      alarm_en      <= 1'b0;
      ringing       <= 1'b0;
      snooze_active <= 1'b0;
      snz_h         <= 5'd0;
      snz_m         <= 6'd0;
      ring_cnt      <= 8'd0;
      prev_seconds  <= 6'd0;
      match_prev    <= 1'b0;
    end else begin
      prev_seconds <= seconds;
      match_prev   <= raw_match;
      case (st)
        RUN: begin
          if (btn_mode) begin
            st        <= SET_H;
            inhours   <= hours;
            inminutes <= minutes;
            inseconds <= 6'd0;
          end else if (match_rise) begin
            st       <= RING;
            ringing  <= 1'b1;
            ring_cnt <= 8'd0;
          end
        end
        SET_H: begin
          if (btn_mode) st <= SET_M;
          else if (edit) inhours <= step_hr(inhours, edit_up);
        end
        SET_M: begin
          if (btn_mode) st <= SET_AH;
          else if (edit) inminutes <= step_min(inminutes, edit_up);
        end
        SET_AH: begin
          if (btn_mode) st <= SET_AM;
          else if (edit) alarm_hours <= step_hr(alarm_hours, edit_up);
        end
        SET_AM: begin
          if (btn_mode) st <= RUN;
          else if (edit) alarm_minutes <= step_min(alarm_minutes, edit_up);
        end
        RING: begin
          if (btn_mode || btn_alarm) begin
            st            <= RUN;
            ringing       <= 1'b0;
            snooze_active <= 1'b0;
            if (btn_alarm) alarm_en <= 1'b0;
          end else if (btn_snooze) begin
            st            <= RUN;
            ringing       <= 1'b0;
            snz_h         <= snz_h_next;
            snz_m         <= snz_m_next;
            snooze_active <= 1'b1;
          end else if (sec_changed) begin
            ring_cnt <= ring_cnt + 8'd1;
            if (ring_cnt == RING_LAST) begin
              st            <= RUN;
              ringing       <= 1'b0;
              snooze_active <= 1'b0;
            end
          end
        end
        default: begin
          st      <= RUN;
          ringing <= 1'b0;
        end
      endcase
      // Outside RING the alarm button is a plain toggle; disarming drops any pending snooze.
      if (btn_alarm && st != RING) begin
        alarm_en <= ~alarm_en;
        if (alarm_en) snooze_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alarm_mode_controller.sv
// Directed bench for alarm_mode_controller: expectations queued per step, checked after the edge.
module tb_alarm_mode_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_up, btn_down, btn_alarm, btn_snooze;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic [2:0] state;
  logic [5:0] inseconds, inminutes;
  logic [4:0] inhours, alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_en, ringing, snooze_active;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int F_STATE = 0, F_INS = 1, F_INM = 2, F_INH = 3, F_AH = 4,
                 F_AM = 5, F_EN = 6, F_RING = 7, F_SNZ = 8;

  typedef struct {
    string      tag;
    int         fld;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alarm_mode_controller dut (
    .CLK100MHZ    (clk),
    .reset        (reset),
    .btn_mode     (btn_mode),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_alarm    (btn_alarm),
    .btn_snooze   (btn_snooze),
    .seconds      (seconds),
    .minutes      (minutes),
    .hours        (hours),
    .state        (state),
    .inseconds    (inseconds),
    .inminutes    (inminutes),
    .inhours      (inhours),
    .alarm_hours  (alarm_hours),
    .alarm_minutes(alarm_minutes),
    .alarm_en     (alarm_en),
    .ringing      (ringing),
    .snooze_active(snooze_active)
  );

  function automatic logic [7:0] get(input int f);
    logic [7:0] r;
    case (f)
      F_STATE: r = {5'd0, state};
      F_INS:   r = {2'd0, inseconds};
      F_INM:   r = {2'd0, inminutes};
      F_INH:   r = {3'd0, inhours};
      F_AH:    r = {3'd0, alarm_hours};
      F_AM:    r = {2'd0, alarm_minutes};
      F_EN:    r = {7'd0, alarm_en};
      F_RING:  r = {7'd0, ringing};
      default: r = {7'd0, snooze_active};
    endcase
    return r;
  endfunction

  task automatic want(input string tag, input int f, input int v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.val = 8'(v);
    q.push_back(e);
  endtask

  // One clock edge; buttons are single-cycle pulses, then every queued expectation is checked.
  task automatic tick();
    logic [7:0] obs;
    @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_alarm = 1'b0; btn_snooze = 1'b0;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      obs = get(e.fld);
      n_cmp++;
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
  endtask

  initial begin
    reset = 1'b1;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_alarm = 1'b0; btn_snooze = 1'b0;
    set_time(10, 15, 37);

    // Reset values
    want("rst_state", F_STATE, 0); want("rst_ah", F_AH, 6); want("rst_am", F_AM, 0);
    want("rst_en", F_EN, 0); want("rst_ring", F_RING, 0); want("rst_snz", F_SNZ, 0);
    want("rst_inh", F_INH, 0);
    tick();
    reset = 1'b0;
    want("rel_state", F_STATE, 0);
    tick();

    // Time edit: snapshot, hour wrap both ways
    btn_mode = 1'b1;
    want("seth_state", F_STATE, 1); want("snap_h", F_INH, 10); want("snap_m", F_INM, 15);
    want("snap_s", F_INS, 0);
    tick();
    for (int i = 0; i < 14; i++) begin
      btn_up = 1'b1;
      if (i == 12) want("inh_23", F_INH, 23);
      if (i == 13) want("inh_wrap0", F_INH, 0);
      tick();
    end
    btn_down = 1'b1; want("inh_dn_wrap", F_INH, 23); tick();
    btn_up = 1'b1;   want("inh_up_wrap", F_INH, 0);  tick();
    btn_mode = 1'b1;
    want("setm_state", F_STATE, 2); want("setm_inh", F_INH, 0); want("setm_inm", F_INM, 15);
    tick();
    for (int i = 0; i < 15; i++) begin
      btn_down = 1'b1;
      if (i == 14) want("inm_0", F_INM, 0);
      tick();
    end
    btn_down = 1'b1; want("inm_dn_wrap", F_INM, 59); tick();
    btn_up = 1'b1;   want("inm_up_wrap", F_INM, 0);  tick();
    btn_down = 1'b1; want("inm_59", F_INM, 59);      tick();

    // Button conflicts
    btn_up = 1'b1; btn_down = 1'b1;
    want("updn_inm", F_INM, 59); want("updn_state", F_STATE, 2);
    tick();
    btn_mode = 1'b1; btn_up = 1'b1;
    want("modeup_state", F_STATE, 3); want("modeup_inm", F_INM, 59); want("modeup_ah", F_AH, 6);
    tick();
    btn_up = 1'b1; btn_down = 1'b1; want("updn_ah", F_AH, 6); tick();

    // Alarm 07:30
    btn_up = 1'b1; want("ah_7", F_AH, 7); tick();
    btn_mode = 1'b1; want("setam_state", F_STATE, 4); tick();
    btn_down = 1'b1; want("am_dn_wrap", F_AM, 59); tick();
    for (int i = 0; i < 29; i++) begin
      btn_down = 1'b1;
      if (i == 28) want("am_30", F_AM, 30);
      tick();
    end
    btn_mode = 1'b1; btn_down = 1'b1;
    want("run_state", F_STATE, 0); want("mode_dn_am", F_AM, 30);
    tick();
    btn_up = 1'b1;
    want("run_up_state", F_STATE, 0); want("run_up_ah", F_AH, 7); want("run_up_inh", F_INH, 0);
    tick();
    btn_alarm = 1'b1; want("arm", F_EN, 1); tick();

    // Alarm match and dismissal within the matching second
    set_time(7, 30, 59); want("pre_match", F_STATE, 0); tick();
    seconds = 6'd0;
    want("ring_state", F_STATE, 5); want("ring_on", F_RING, 1);
    tick();
    want("ring_hold", F_STATE, 5); tick();
    btn_mode = 1'b1;
    want("dismiss_state", F_STATE, 0); want("dismiss_ring", F_RING, 0); want("dismiss_snz", F_SNZ, 0);
    tick();
    want("no_retrig1", F_STATE, 0); tick();
    want("no_retrig2", F_RING, 0);  tick();

    // Move alarm to 23:58
    btn_mode = 1'b1; want("a2_seth", F_STATE, 1); want("a2_snap_h", F_INH, 7); tick();
    btn_mode = 1'b1; want("a2_setm", F_STATE, 2); tick();
    btn_mode = 1'b1; want("a2_setah", F_STATE, 3); tick();
    for (int i = 0; i < 8; i++) begin
      btn_down = 1'b1;
      if (i == 7) want("ah_23", F_AH, 23);
      tick();
    end
    btn_mode = 1'b1; want("a2_setam", F_STATE, 4); tick();
    for (int i = 0; i < 28; i++) begin
      btn_up = 1'b1;
      if (i == 27) want("am_58", F_AM, 58);
      tick();
    end
    btn_mode = 1'b1; want("a2_run", F_STATE, 0); tick();

    // Snooze across midnight
    set_time(23, 58, 59); want("pre2", F_STATE, 0); tick();
    seconds = 6'd0; want("ring2", F_STATE, 5); tick();
    seconds = 6'd12; want("ring2_hold", F_RING, 1); tick();
    btn_snooze = 1'b1;
    want("snz_state", F_STATE, 0); want("snz_ring", F_RING, 0); want("snz_act", F_SNZ, 1);
    tick();
    set_time(0, 2, 59); want("snz_pre", F_STATE, 0); tick();
    set_time(0, 3, 0);
    want("snz_fire", F_STATE, 5); want("snz_fire_ring", F_RING, 1); want("snz_still", F_SNZ, 1);
    tick();

    // Auto-silence on the 60th observed seconds change
    for (int i = 0; i < 60; i++) begin
      seconds = 6'((i + 1) % 60);
      if (seconds == 6'd0) minutes = 6'd4;
      if (i == 58) want("ring_59th", F_STATE, 5);
      if (i == 59) begin
        want("to_state", F_STATE, 0); want("to_ring", F_RING, 0); want("to_snz", F_SNZ, 0);
      end
      tick();
    end
    want("to_stay", F_STATE, 0); tick();

    // Disarming in RUN clears a pending snooze
    set_time(23, 58, 30); tick();
    seconds = 6'd0; want("ring3", F_STATE, 5); tick();
    btn_snooze = 1'b1; want("snz3", F_SNZ, 1); tick();
    btn_alarm = 1'b1; want("disarm_en", F_EN, 0); want("disarm_snz", F_SNZ, 0); tick();
    btn_alarm = 1'b1; want("rearm_en", F_EN, 1); want("rearm_snz", F_SNZ, 0); tick();

    // btn_alarm while ringing dismisses and disarms
    seconds = 6'd1; tick();
    seconds = 6'd0; want("ring4", F_STATE, 5); tick();
    btn_alarm = 1'b1;
    want("adis_state", F_STATE, 0); want("adis_ring", F_RING, 0); want("adis_en", F_EN, 0);
    tick();

    // Reset during RING
    btn_alarm = 1'b1; want("arm5", F_EN, 1); tick();
    seconds = 6'd1; tick();
    seconds = 6'd0; want("ring5", F_STATE, 5); tick();
    reset = 1'b1;
    want("rr_state", F_STATE, 0); want("rr_ring", F_RING, 0); want("rr_en", F_EN, 0);
    want("rr_ah", F_AH, 6); want("rr_am", F_AM, 0); want("rr_inm", F_INM, 0);
    tick();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
